// File: rtl/coeff_quantizer.sv
// rtl/coeff_quantizer.sv - 3-stage reciprocal quantizer for 8x8 coefficient blocks
module coeff_quantizer #(
  parameter int W_IN = 12,
  parameter int W_R  = 17,
  parameter int FRAC = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ena_in,
  input  logic [W_IN-1:0] S_in,
  input  logic            qt_we,
  input  logic [5:0]      qt_addr,
  input  logic [W_R-1:0]  qt_data,
  output logic [W_IN-1:0] Q_out,
  output logic            valid_out,
  output logic [5:0]      pos_out,
  output logic            blk_start_out
);
  localparam int W_P = W_IN + W_R;
  localparam int W_Q = W_P - FRAC + 1;
  localparam logic [W_P:0]   HALF    = (W_P+1)'(1) << (FRAC - 1);
  localparam logic [W_Q-1:0] LIM_POS = W_Q'((1 << (W_IN - 1)) - 1);
  localparam logic [W_Q-1:0] LIM_NEG = W_Q'(1 << (W_IN - 1));

  logic [W_R-1:0]  mem [64];
  logic [5:0]      pos;

  logic            s1_v, s1_sign;
  logic [W_IN-1:0] s1_mag;
  logic [5:0]      s1_pos;
  logic [W_R-1:0]  s1_r;

  logic            s2_v, s2_sign;
  logic [W_P-1:0]  s2_prod;
  logic [5:0]      s2_pos;

  logic [W_P:0]    rnd;
  logic [W_Q-1:0]  qfull, qlim;
  logic [W_IN-1:0] qmag, qsigned;

  // Table is deliberately outside reset; the read register sees the pre-write value.
  always_ff @(posedge clk) begin
    if (qt_we) mem[qt_addr] <= qt_data;
    s1_r <= mem[pos];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pos  <= '0;
      s1_v <= 1'b0;
      s2_v <= 1'b0;
    end else begin
      s1_v <= ena_in;
      s2_v <= s1_v;
      if (ena_in) pos <= pos + 6'd1;
    end
    s1_sign <= S_in[W_IN-1];
    s1_mag  <= S_in[W_IN-1] ? -S_in : S_in;
    s1_pos  <= pos;
    s2_sign <= s1_sign;
    s2_pos  <= s1_pos;
    s2_prod <= W_P'(s1_mag) * W_P'(s1_r);
  end

  // Rounding in the magnitude domain gives half-away-from-zero after re-signing.
  always_comb begin
    rnd     = {1'b0, s2_prod} + HALF;
    qfull   = W_Q'(rnd >> FRAC);
    qlim    = s2_sign ? LIM_NEG : LIM_POS;
    qmag    = (qfull > qlim) ? qlim[W_IN-1:0] : qfull[W_IN-1:0];
    qsigned = s2_sign ? -qmag : qmag;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_out     <= 1'b0;
      blk_start_out <= 1'b0;
      pos_out       <= '0;
      Q_out         <= '0;
    end else begin
      valid_out <= s2_v;
      if (s2_v) begin
        Q_out         <= qsigned;
        pos_out       <= s2_pos;
        blk_start_out <= (s2_pos == 6'd0);
      end else begin
        blk_start_out <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_coeff_quantizer.sv
// tb/tb_coeff_quantizer.sv - directed and randomized self-check of coeff_quantizer
module tb_coeff_quantizer;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ena_in = 1'b0;
  logic [11:0] S_in = '0;
  logic        qt_we = 1'b0;
  logic [5:0]  qt_addr = '0;
  logic [16:0] qt_data = '0;
  logic [11:0] Q_out;
  logic        valid_out;
  logic [5:0]  pos_out;
  logic        blk_start_out;

  coeff_quantizer dut (
    .clk(clk), .rst(rst), .ena_in(ena_in), .S_in(S_in),
    .qt_we(qt_we), .qt_addr(qt_addr), .qt_data(qt_data),
    .Q_out(Q_out), .valid_out(valid_out), .pos_out(pos_out),
    .blk_start_out(blk_start_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [11:0] q;
    logic [5:0]  p;
  } ent_t;

  ent_t        pipe [3];
  logic [16:0] tbl [64];
  int          bpos = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_valid = 0;
  int          n_blk = 0;
  logic [11:0] last_q = '0;
  logic [5:0]  last_pos = '0;

  function automatic logic [11:0] model(input logic [11:0] s, input logic [16:0] r);
    longint sv, mag, q;
    sv  = longint'($signed(s));
    mag = (sv < 0) ? -sv : sv;
    q   = (mag * longint'(r) + 32768) / 65536;
    if (sv < 0) begin
      if (q > 2048) q = 2048;
      return 12'(-q);
    end
    if (q > 2047) q = 2047;
    return 12'(q);
  endfunction

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance, then compare outputs against the expected pipeline.
  task automatic cyc(input logic en, input logic [11:0] s, input logic use_hand,
                     input logic [11:0] hand, input logic do_rst);
    ent_t e;
    ena_in = en; S_in = s; rst = do_rst;
    e.v = en && !do_rst;
    e.p = 6'(bpos);
    e.q = use_hand ? hand : model(s, tbl[bpos]);
    if (e.v) bpos = (bpos + 1) % 64;
    if (qt_we) tbl[qt_addr] = qt_data;
    @(posedge clk); #1;
    pipe[2] = pipe[1]; pipe[1] = pipe[0]; pipe[0] = e;
    if (do_rst) begin
      for (int i = 0; i < 3; i++) pipe[i].v = 1'b0;
      bpos = 0; last_q = '0; last_pos = '0;
    end
    chk("valid_out", 12'(valid_out), 12'(pipe[2].v));
    if (valid_out) begin
      n_valid++;
      if (blk_start_out) n_blk++;
    end
    if (pipe[2].v) begin
      chk("Q_out", Q_out, pipe[2].q);
      chk("pos_out", 12'(pos_out), 12'(pipe[2].p));
      chk("blk_start_out", 12'(blk_start_out), 12'(pipe[2].p == 6'd0));
      last_q = pipe[2].q; last_pos = pipe[2].p;
    end else begin
      chk("Q_out_hold", Q_out, last_q);
      chk("pos_out_hold", 12'(pos_out), 12'(last_pos));
      chk("blk_start_idle", 12'(blk_start_out), 12'd0);
    end
    qt_we = 1'b0; rst = 1'b0; ena_in = 1'b0;
  endtask

  task automatic wr(input logic [5:0] a, input logic [16:0] d);
    qt_we = 1'b1; qt_addr = a; qt_data = d;
  endtask

  task automatic send(input logic [11:0] s, input logic [11:0] hand);
    cyc(1'b1, s, 1'b1, hand, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 12'd0, 1'b1, 12'd0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) pipe[i] = '{v: 1'b0, q: 12'd0, p: 6'd0};
    for (int i = 0; i < 64; i++) tbl[i] = '0;

    cyc(1'b0, 12'd0, 1'b1, 12'd0, 1'b1);
    cyc(1'b0, 12'd0, 1'b1, 12'd0, 1'b1);
    chk("reset_Q_out", Q_out, 12'd0);
    chk("reset_pos_out", 12'(pos_out), 12'd0);
    chk("reset_valid_out", 12'(valid_out), 12'd0);
    chk("reset_blk_start", 12'(blk_start_out), 12'd0);

    for (int i = 0; i < 64; i++) begin
      wr(6'(i), 17'd4096);
      idle(1);
    end

    // Q=16: 100->6, -100->-6, 24->2 (1.5 rounds up), 8->1 (0.5 up), -7->0 (+0), 0->0
    send(12'd100, 12'd6);
    send(-12'sd100, -12'sd6);
    send(12'd24, 12'd2);
    send(-12'sd24, -12'sd2);
    send(12'd8, 12'd1);
    send(-12'sd7, 12'd0);
    send(12'd0, 12'd0);
    idle(3);

    // Full-scale with Q=1, and R=0
    cyc(1'b0, 12'd0, 1'b1, 12'd0, 1'b1);
    wr(6'd0, 17'd65536); idle(1);
    wr(6'd1, 17'd65536); idle(1);
    wr(6'd2, 17'd0);     idle(1);
    send(12'h800, 12'h800);
    send(12'd2047, 12'd2047);
    send(12'd1000, 12'd0);

    // Write to address 5 in the same cycle the pos-5 sample enters
    send(12'd160, 12'd10);
    send(12'd160, 12'd10);
    wr(6'd5, 17'd8192);
    send(12'd160, 12'd10);
    for (int i = 6; i < 64; i++) send(12'd0, 12'd0);
    for (int i = 0; i < 5; i++) send(12'd0, 12'd0);
    send(12'd160, 12'd20);

    // Reset with pos-10 and pos-11 samples in flight
    for (int i = 6; i < 10; i++) send(12'd0, 12'd0);
    send(12'd160, 12'd10);
    send(-12'sd160, -12'sd10);
    cyc(1'b0, 12'd0, 1'b1, 12'd0, 1'b1);
    idle(3);
    send(12'd48, 12'd48);
    send(-12'sd5, -12'sd5);
    send(12'd700, 12'd0);
    send(12'd0, 12'd0);
    send(12'd0, 12'd0);
    send(-12'sd160, -12'sd20);
    idle(3);

    // 130 coefficients with random gaps: three block starts
    cyc(1'b0, 12'd0, 1'b1, 12'd0, 1'b1);
    n_valid = 0; n_blk = 0;
    for (int i = 0; i < 130; i++) begin
      if ($urandom_range(2, 0) == 0) idle($urandom_range(3, 1));
      cyc(1'b1, 12'($urandom), 1'b0, 12'd0, 1'b0);
    end
    idle(3);
    chk("wrap_valid_count", 12'(n_valid), 12'd130);
    chk("wrap_blk_count", 12'(n_blk), 12'd3);

    // Random coefficients, random table rewrites, random gaps
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(7, 0) == 0) wr(6'($urandom), 17'($urandom_range(65536, 0)));
      cyc($urandom_range(3, 0) != 0, 12'($urandom), 1'b0, 12'd0, 1'b0);
    end
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
